// File: rtl/bp_be_stride_pf_gen.sv
// Stride prefetch address generator: expands confirmed RPT stride events into
// block-aligned prefetch addresses queued in a small circular FIFO.
module bp_be_stride_pf_gen #(
  parameter int vaddr_width_p        = 39,  // virtual address width of the processor config
  parameter int stride_width_p       = 8,
  parameter int degree_p             = 4,
  parameter int fifo_els_p           = 4,
  parameter int block_offset_width_p = 6
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  base_addr_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_yumi_i,
  output logic                      busy_o
);

  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int rem_w = $clog2(degree_p + 1);
  localparam logic [vaddr_width_p-1:0] blk_mask_lp =
    {{(vaddr_width_p-block_offset_width_p){1'b1}}, {block_offset_width_p{1'b0}}};

  typedef enum logic [1:0] {e_off, e_discover, e_confirmed} mode_e;
  typedef enum logic {e_idle, e_gen} gen_e;

  mode_e                     mode_q, mode_d;
  gen_e                      gen_q, gen_d;
  logic [vaddr_width_p-1:0]  cur_q, cur_d;
  logic [vaddr_width_p-1:0]  stride_q, stride_d;
  logic [vaddr_width_p-1:0]  last_blk_q, last_blk_d;
  logic [vaddr_width_p-1:0]  pc_q, pc_d;
  logic [rem_w-1:0]          rem_q, rem_d;
  logic [ptr_w-1:0]          rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0]          wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0]          count_q, count_d;
  logic [vaddr_width_p-1:0]  mem_q [fifo_els_p];

  logic                      accept;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [vaddr_width_p-1:0]  cand;
  logic [vaddr_width_p-1:0]  blk;

  always_comb begin
    mode_d = mode_q;
    if (confirm_discovery_i) begin
      mode_d = e_confirmed;
    end else if (start_discovery_i) begin
      mode_d = e_discover;
    end
  end

  assign accept     = stride_v_i && (stride_i != '0) && (mode_d != e_off);
  assign fifo_full  = (count_q == cnt_w'(fifo_els_p));
  assign fifo_empty = (count_q == '0);
  assign cand       = cur_q + stride_q;
  assign blk        = cand & blk_mask_lp;

  // A preempting event abandons the old step in the same cycle, so no push then.
  assign push = (gen_q == e_gen) && !accept && !fifo_full && (blk != last_blk_q);
  assign pop  = pf_yumi_i && !fifo_empty;

  always_comb begin
    gen_d      = gen_q;
    cur_d      = cur_q;
    stride_d   = stride_q;
    last_blk_d = last_blk_q;
    pc_d       = pc_q;
    rem_d      = rem_q;
    if (accept) begin
      gen_d      = e_gen;
      cur_d      = base_addr_i;
      stride_d   = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
      last_blk_d = base_addr_i & blk_mask_lp;
      pc_d       = pc_i;
      rem_d      = (mode_d == e_confirmed) ? rem_w'(degree_p) : rem_w'(1);
    end else if ((gen_q == e_gen) && !fifo_full) begin
      // Duplicate blocks are skipped but still spend one unit of degree.
      cur_d      = cand;
      last_blk_d = blk;
      rem_d      = rem_q - rem_w'(1);
      if (rem_q == rem_w'(1)) begin
        gen_d = e_idle;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_w'(fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_w'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == ptr_w'(fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_w'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_q     <= e_off;
      gen_q      <= e_idle;
      cur_q      <= '0;
      stride_q   <= '0;
      last_blk_q <= '0;
      pc_q       <= '0;
      rem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      gen_q      <= gen_d;
      cur_q      <= cur_d;
      stride_q   <= stride_d;
      last_blk_q <= last_blk_d;
      pc_q       <= pc_d;
      rem_q      <= rem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Slots are reset so the head reads zero out of reset.
  for (genvar gi = 0; gi < fifo_els_p; gi++) begin : g_slot
    logic [vaddr_width_p-1:0] slot_d;

    always_comb begin
      slot_d = mem_q[gi];
      if (push && (wr_ptr_q == ptr_w'(gi))) begin
        slot_d = blk;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= slot_d;
      end
    end
  end

  assign pf_v_o    = !fifo_empty;
  assign pf_addr_o = mem_q[rd_ptr_q];
  assign busy_o    = (gen_q == e_gen) || !fifo_empty;

endmodule

// File: tb/tb_bp_be_stride_pf_gen.sv
// Bench for bp_be_stride_pf_gen: a depth-4 and a depth-2 instance share stimulus;
// expected prefetch addresses are queued per instance and compared on each pop.
module tb_bp_be_stride_pf_gen;

  localparam int VW = 39;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stride_v = 1'b0;
  logic [SW-1:0] stride = '0;
  logic [VW-1:0] pc = '0;
  logic [VW-1:0] base = '0;
  logic          start_d = 1'b0;
  logic          confirm_d = 1'b0;
  logic          en_a = 1'b0;
  logic          en_b = 1'b0;

  logic          pf_v_a, pf_v_b, busy_a, busy_b, yumi_a, yumi_b;
  logic [VW-1:0] pf_addr_a, pf_addr_b;

  int errors = 0;
  int checks = 0;
  logic [VW-1:0] exp_a [$];
  logic [VW-1:0] exp_b [$];
  logic [VW-1:0] ea, eb;

  always #5 clk = ~clk;

  assign yumi_a = en_a & pf_v_a;
  assign yumi_b = en_b & pf_v_b;

  bp_be_stride_pf_gen #(.vaddr_width_p(VW), .stride_width_p(SW), .degree_p(4),
                        .fifo_els_p(4), .block_offset_width_p(6)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .stride_v_i(stride_v), .stride_i(stride),
    .pc_i(pc), .base_addr_i(base), .start_discovery_i(start_d),
    .confirm_discovery_i(confirm_d), .pf_v_o(pf_v_a), .pf_addr_o(pf_addr_a),
    .pf_yumi_i(yumi_a), .busy_o(busy_a)
  );

  bp_be_stride_pf_gen #(.vaddr_width_p(VW), .stride_width_p(SW), .degree_p(4),
                        .fifo_els_p(2), .block_offset_width_p(6)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .stride_v_i(stride_v), .stride_i(stride),
    .pc_i(pc), .base_addr_i(base), .start_discovery_i(start_d),
    .confirm_discovery_i(confirm_d), .pf_v_o(pf_v_b), .pf_addr_o(pf_addr_b),
    .pf_yumi_i(yumi_b), .busy_o(busy_b)
  );

  // Scoreboards: every pop must match the oldest outstanding expected address.
  always @(negedge clk) begin
    if (reset_n && en_a && pf_v_a) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL pop_a: got unexpected addr %h, required no request", pf_addr_a);
      end else begin
        ea = exp_a.pop_front();
        if (pf_addr_a !== ea) begin
          errors++;
          $display("FAIL pop_a: got %h required %h", pf_addr_a, ea);
        end else begin
          $display("pop A addr=%h", pf_addr_a);
        end
      end
    end
    if (reset_n && en_b && pf_v_b) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL pop_b: got unexpected addr %h, required no request", pf_addr_b);
      end else begin
        eb = exp_b.pop_front();
        if (pf_addr_b !== eb) begin
          errors++;
          $display("FAIL pop_b: got %h required %h", pf_addr_b, eb);
        end else begin
          $display("pop B addr=%h", pf_addr_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    stride_v  = 1'b0;
    start_d   = 1'b0;
    confirm_d = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_confirm();
    confirm_d = 1'b1;
    tick();
    confirm_d = 1'b0;
  endtask

  // Drives one event cycle t; returns at the start of cycle t+1.
  task automatic send_event(input logic [VW-1:0] b, input logic [SW-1:0] s, input logic st);
    stride_v = 1'b1;
    stride   = s;
    base     = b;
    pc       = VW'($urandom);
    start_d  = st;
    $display("event base=%h stride=%h start=%0d", b, s, st);
    tick();
    stride_v = 1'b0;
    start_d  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (pf_v_a !== 1'b0) begin errors++; $display("FAIL reset_pf_v_a: got %b required 0", pf_v_a); end
    checks++; if (pf_addr_a !== '0) begin errors++; $display("FAIL reset_pf_addr_a: got %h required 0", pf_addr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b required 0", busy_a); end
    checks++; if (pf_v_b !== 1'b0) begin errors++; $display("FAIL reset_pf_v_b: got %b required 0", pf_v_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b required 0", busy_b); end
  endtask

  task automatic test_confirmed();
    do_reset();
    en_a = 1'b1;
    pulse_confirm();
    exp_a.push_back(VW'('h1040));
    exp_a.push_back(VW'('h1080));
    exp_a.push_back(VW'('h10C0));
    exp_a.push_back(VW'('h1100));
    send_event(VW'('h1000), 8'h40, 1'b0);
    @(negedge clk); // t+1
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL conf_busy_t1: got %b required 1", busy_a); end
    checks++; if (pf_v_a !== 1'b0) begin errors++; $display("FAIL conf_pf_v_t1: got %b required 0", pf_v_a); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (pf_v_a !== 1'b1) begin errors++; $display("FAIL conf_pf_v_t%0d: got %b required 1", k, pf_v_a); end
    end
    @(negedge clk); // t+6
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL conf_busy_t6: got %b required 0", busy_a); end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL conf_drain: got %0d left required 0", exp_a.size()); end
  endtask

  task automatic test_discovery();
    do_reset();
    en_a = 1'b1;
    exp_a.push_back(VW'('h2040));
    send_event(VW'('h2000), 8'h40, 1'b1);
    @(negedge clk); // t+1
    @(negedge clk); // t+2
    checks++; if (pf_addr_a !== VW'('h2040)) begin errors++; $display("FAIL disc_addr_t2: got %h required 2040", pf_addr_a); end
    @(negedge clk); // t+3
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL disc_busy_t3: got %b required 0", busy_a); end
    repeat (4) @(negedge clk);
    checks++; if (pf_v_a !== 1'b0) begin errors++; $display("FAIL disc_extra: got pf_v %b required 0", pf_v_a); end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL disc_drain: got %0d left required 0", exp_a.size()); end
  endtask

  task automatic test_same_block();
    do_reset();
    en_a = 1'b1;
    pulse_confirm();
    send_event(VW'('h1000), 8'h08, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || pf_v_a !== 1'b0) begin
        errors++;
        $display("FAIL same_blk_t%0d: got busy %b pf_v %b required busy 1 pf_v 0", k, busy_a, pf_v_a);
      end
    end
    @(negedge clk); // t+5
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL same_blk_busy_t5: got %b required 0", busy_a); end
  endtask

  task automatic test_negative();
    logic [VW-1:0] w;
    do_reset();
    en_a = 1'b1;
    pulse_confirm();
    exp_a.push_back(VW'('h0FC0));
    exp_a.push_back(VW'('h0F80));
    exp_a.push_back(VW'('h0F40));
    exp_a.push_back(VW'('h0F00));
    send_event(VW'('h1000), 8'hC0, 1'b0);
    for (int i = 0; i < 30 && (exp_a.size() != 0 || busy_a); i++) @(negedge clk);
    checks++; if (exp_a.size() != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL neg_drain: got %0d left busy %b required 0 left busy 0", exp_a.size(), busy_a); end
    tick();
    w = '0;
    for (int k = 0; k < 4; k++) begin
      w = w - VW'(64);
      exp_a.push_back(w);
    end
    send_event(VW'(0), 8'hC0, 1'b0);
    for (int i = 0; i < 30 && (exp_a.size() != 0 || busy_a); i++) @(negedge clk);
    checks++; if (exp_a.size() != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %0d left busy %b required 0 left busy 0", exp_a.size(), busy_a); end
  endtask

  task automatic test_stall_preempt();
    do_reset();
    pulse_confirm();
    exp_b.push_back(VW'('h1040));
    exp_b.push_back(VW'('h1080));
    exp_b.push_back(VW'('h10C0));
    exp_b.push_back(VW'('h1100));
    send_event(VW'('h1000), 8'h40, 1'b0);
    repeat (6) @(negedge clk);
    checks++; if (pf_addr_b !== VW'('h1040) || pf_v_b !== 1'b1) begin errors++; $display("FAIL stall_head: got v %b addr %h required v 1 addr 1040", pf_v_b, pf_addr_b); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b required 1", busy_b); end
    tick();
    en_b = 1'b1;
    for (int i = 0; i < 30 && (exp_b.size() != 0 || busy_b); i++) @(negedge clk);
    checks++; if (exp_b.size() != 0 || busy_b !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0d left busy %b required 0 left busy 0", exp_b.size(), busy_b); end
    tick();
    en_b = 1'b0;
    exp_b.push_back(VW'('h5040));
    exp_b.push_back(VW'('h5080));
    send_event(VW'('h5000), 8'h40, 1'b0);
    repeat (5) @(negedge clk);
    tick();
    exp_b.push_back(VW'('h8040));
    exp_b.push_back(VW'('h8080));
    exp_b.push_back(VW'('h80C0));
    exp_b.push_back(VW'('h8100));
    send_event(VW'('h8000), 8'h40, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (pf_addr_b !== VW'('h5040)) begin errors++; $display("FAIL preempt_keep: got %h required 5040", pf_addr_b); end
    tick();
    en_b = 1'b1;
    for (int i = 0; i < 30 && (exp_b.size() != 0 || busy_b); i++) @(negedge clk);
    checks++; if (exp_b.size() != 0 || busy_b !== 1'b0) begin errors++; $display("FAIL preempt_drain: got %0d left busy %b required 0 left busy 0", exp_b.size(), busy_b); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_confirm();
    send_event(VW'('h3000), 8'h40, 1'b0);
    repeat (4) @(negedge clk); // t+4: three entries queued
    checks++; if (pf_v_a !== 1'b1 || pf_addr_a !== VW'('h3040)) begin errors++; $display("FAIL mid_pre: got v %b addr %h required v 1 addr 3040", pf_v_a, pf_addr_a); end
    reset_n = 1'b0;
    #1;
    checks++; if (pf_v_a !== 1'b0) begin errors++; $display("FAIL mid_pf_v: got %b required 0", pf_v_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy_a); end
    checks++; if (pf_addr_a !== '0) begin errors++; $display("FAIL mid_addr: got %h required 0", pf_addr_a); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    en_a = 1'b1;
    send_event(VW'('h4000), 8'h40, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (pf_v_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL off_ignore_t%0d: got v %b busy %b required 0 0", k, pf_v_a, busy_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_confirmed();
    test_discovery();
    test_same_block();
    test_negative();
    test_stall_preempt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
